gpio_irq: RTL and testbench
===========================

# gpio_irq

Parametrised memory-mapped GPIO controller: N buttons, N switches, N LEDs, with per-input synchronisation, debouncing, edge detection and a maskable level interrupt. Sits on the CPU's word-addressed peripheral bus (4-bit word address, 32-bit data, single-cycle write strobe, combinational read). It supersedes the fixed 2-button/2-switch/4-LED GPIO block and drives the interrupt controller through `irq`.

## Interface
- `NBTN`, 2: button inputs; NBTN+NSW ≤ 32
- `NSW`, 2: switch inputs
- `NLED`, 4: LED outputs; ≤ 32
- `DEB_CYCLES`, 16: debounce stability window in clk cycles; ≥ 1
- `clk`  in  1: sole clock; all state on posedge
- `rst`  in  1: synchronous, active-high reset
- `a`  in  4: word address
- `d`  in  32: write data, LSB-aligned
- `we`  in  1: write strobe, one write per cycle
- `spo`  out  32: combinational read data for `a`
- `btn`  in  NBTN: asynchronous button pins
- `sw`  in  NSW: asynchronous switch pins
- `led`  out  NLED: LED drive, registered
- `irq`  out  1: level interrupt, registered

## Operation
- Input vector `in = {sw, btn}`; bit i < NBTN is btn[i], else sw[i-NBTN]. Width NIN = NBTN+NSW.
- Per input: 2-flop synchroniser → debouncer → stable bit `deb[i]` → edge detector against `deb_d[i]`.
- Debouncer: counter clears whenever sync output equals `deb[i]`; otherwise increments. When sync has differed for DEB_CYCLES consecutive cycles, `deb[i]` takes the new value and the counter clears.
- Register map (unlisted addresses read 0, writes ignored):
  - 0 IN (RO): {zeros, deb}
  - 1 LED (RW): led[NLED-1:0] ← d[NLED-1:0]
  - 2 LED_SET (WO, reads 0): led |= d
  - 3 LED_CLR (WO, reads 0): led &= ~d
  - 4 IRQ_EN (RW): per-input mask
  - 5 IRQ_PEND (R, W1C): sticky edge flags
  - 6 EDGE_SEL (RW): bit=0 rising edge, bit=1 falling edge sets pend
- pend[i] sets on the selected edge of deb[i] (deb ≠ deb_d).
- Same-cycle edge and W1C on the same bit: set wins.
- `irq` ← |(pend & irq_en), registered.
- Bits above NIN/NLED: write-ignored, read 0.

## Timing
- Reset values: led all ones; irq_en, pend, edge_sel, deb, deb_d, synchronisers, counters, irq all 0.
- Pin change to `deb`: 2 sync cycles + DEB_CYCLES cycles. Glitch shorter than DEB_CYCLES never reaches `deb`.
- `deb` change → pend set on the next edge → `irq` one edge later.
- Writes take effect on the clk edge where `we` is high; `spo` reflects new value from that edge on.
- An input held high through reset produces a rising edge once debounced, so pend sets; software clears it after boot.
- `rst` mid-debounce discards the count; mid-pending clears pend and irq the same edge.

## Configuration
- `GPIO_IRQ_DEBOUNCE_EN` defined: debouncers instantiated as above.
- Undefined: `deb` = synchroniser output directly (pin-to-IN latency 2 cycles); DEB_CYCLES ignored; no counters built.

## Structure
- `gpio_irq_pkg`: address constants (ADDR_IN … ADDR_EDGE_SEL) and edge-select encodings.
- Sub-module `gpio_debounce` (one input, DEB_CYCLES parameter, counter of $clog2(DEB_CYCLES+1) bits), instantiated NIN times by generate.

## Test plan
- Reset with defaults → led=4'b1111, irq=0; reads of addr 0/4/5/6 return 0.
- With debounce enabled, DEB_CYCLES=16: btn[0] high for 10 cycles then low → IN stays 0, pend 0; high for 40 cycles → IN=1 exactly 18 cycles after the pin change.
- IRQ_EN=0x1, EDGE_SEL=0: btn[0] rises → pend=0x1, irq=1 two cycles after IN changes; write 0x1 to addr 5 → pend=0, irq=0 next cycle.
- EDGE_SEL=0x4, IRQ_EN=0x4: sw[0] rises → no pend; falls → pend=0x4; W1C on the same cycle as a new edge → pend remains 0x4.
- LED: write 0x0 to addr 1 → led=0; write 0x5 to addr 2 → led=0x5; write 0x1 to addr 3 → led=0x4; write 0xFFFFFFF0 to addr 1 → led=0x0, read back 0x0.
- Pend set, then rst asserted for one cycle → pend, irq, deb, led return to reset values the same edge.

Source files
------------

// File: rtl/gpio_irq_pkg.sv
// Shared constants for the gpio_irq block: register word addresses and edge-select encodings.
package gpio_irq_pkg;

   localparam logic [3:0] ADDR_IN       = 4'd0;
   localparam logic [3:0] ADDR_LED      = 4'd1;
   localparam logic [3:0] ADDR_LED_SET  = 4'd2;
   localparam logic [3:0] ADDR_LED_CLR  = 4'd3;
   localparam logic [3:0] ADDR_IRQ_EN   = 4'd4;
   localparam logic [3:0] ADDR_IRQ_PEND = 4'd5;
   localparam logic [3:0] ADDR_EDGE_SEL = 4'd6;

   typedef enum logic {
      EDGE_RISE = 1'b0,
      EDGE_FALL = 1'b1
   } edge_sel_e;

   // True when the stable input moved in the direction its edge-select bit asks for.
   function automatic logic edge_hit(input logic cur, input logic prev, input logic sel);
      if (edge_sel_e'(sel) == EDGE_FALL) return ~cur & prev;
      else                               return cur & ~prev;
   endfunction

endpackage

// File: rtl/gpio_irq_if.sv
// Word-addressed peripheral bus between the CPU (master) and gpio_irq (slave).
interface gpio_irq_if;
   // No handshake: a write completes on the clk edge where we is high (one per cycle);
   // spo is a combinational read of the word at a, valid in the same cycle.
   logic [3:0]  a;
   logic [31:0] d;
   logic        we;
   logic [31:0] spo;

   modport master (output a, output d, output we, input spo);
   modport slave  (input a, input d, input we, output spo);
endinterface

// File: rtl/gpio_debounce.sv
// One input: 2-flop synchroniser, then a stability-window debouncer when
// GPIO_IRQ_DEBOUNCE_EN is defined; otherwise the synchroniser output is used directly.
module gpio_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pin,
   output logic o_deb
);

   if (DEB_CYCLES < 1) begin : g_bad_deb
      $error("gpio_debounce: DEB_CYCLES must be >= 1");
   end

   logic [1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[0], i_pin};
   end

`ifdef GPIO_IRQ_DEBOUNCE_EN
   localparam int              CW       = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic          r_deb;

   // The count only runs while the synchronised level disagrees with the stable one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_deb <= 1'b0;
      end else if (r_sync[1] == r_deb) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_deb <= r_sync[1];
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_deb = r_deb;
`else
   assign o_deb = r_sync[1];
`endif

endmodule

// File: rtl/gpio_irq.sv
// Memory-mapped GPIO with debounced inputs, edge-triggered sticky pend flags and a
// maskable level irq. Debouncing is built only when GPIO_IRQ_DEBOUNCE_EN is defined.
module gpio_irq
   import gpio_irq_pkg::*;
#(
   parameter int NBTN       = 2,
   parameter int NSW        = 2,
   parameter int NLED       = 4,
   parameter int DEB_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst,
   gpio_irq_if.slave       bus,
   input  logic [NBTN-1:0] btn,
   input  logic [NSW-1:0]  sw,
   output logic [NLED-1:0] led,
   output logic            irq
);

   localparam int NIN = NBTN + NSW;

   if (NIN > 32 || NLED > 32) begin : g_bad_width
      $error("gpio_irq: NBTN+NSW and NLED must each be <= 32");
   end

   logic [NIN-1:0]  w_in;
   logic [NIN-1:0]  w_deb;
   logic [NIN-1:0]  w_set;
   logic [NIN-1:0]  w_w1c;
   logic [31:0]     w_rdata;
   logic            w_unused_d;

   logic [NIN-1:0]  r_deb_d;
   logic [NIN-1:0]  r_irq_en;
   logic [NIN-1:0]  r_pend;
   logic [NIN-1:0]  r_edge_sel;
   logic [NLED-1:0] r_led;
   logic            r_irq;

   assign w_in       = {sw, btn};
   assign w_unused_d = &{1'b0, bus.d};

   for (genvar g = 0; g < NIN; g++) begin : g_in
      gpio_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk   (clk),
         .rst   (rst),
         .i_pin (w_in[g]),
         .o_deb (w_deb[g])
      );
   end

   always_comb begin
      w_set = '0;
      for (int i = 0; i < NIN; i++) begin
         w_set[i] = edge_hit(w_deb[i], r_deb_d[i], r_edge_sel[i]);
      end
   end

   assign w_w1c = (bus.we && bus.a == ADDR_IRQ_PEND) ? bus.d[NIN-1:0] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_deb_d    <= '0;
         r_irq_en   <= '0;
         r_pend     <= '0;
         r_edge_sel <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_deb_d <= w_deb;
         // A new edge outranks a same-cycle software clear of that bit.
         r_pend  <= (r_pend & ~w_w1c) | w_set;
         r_irq   <= |(r_pend & r_irq_en);
         if (bus.we && bus.a == ADDR_IRQ_EN)   r_irq_en   <= bus.d[NIN-1:0];
         if (bus.we && bus.a == ADDR_EDGE_SEL) r_edge_sel <= bus.d[NIN-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_led <= '1;
      end else if (bus.we) begin
         case (bus.a)
            ADDR_LED:     r_led <= bus.d[NLED-1:0];
            ADDR_LED_SET: r_led <= r_led | bus.d[NLED-1:0];
            ADDR_LED_CLR: r_led <= r_led & ~bus.d[NLED-1:0];
            default:      r_led <= r_led;
         endcase
      end
   end

   always_comb begin
      w_rdata = '0;
      case (bus.a)
         ADDR_IN:       w_rdata = 32'(w_deb);
         ADDR_LED:      w_rdata = 32'(r_led);
         ADDR_IRQ_EN:   w_rdata = 32'(r_irq_en);
         ADDR_IRQ_PEND: w_rdata = 32'(r_pend);
         ADDR_EDGE_SEL: w_rdata = 32'(r_edge_sel);
         default:       w_rdata = '0;
      endcase
   end

   assign bus.spo = w_rdata;
   assign led     = r_led;
   assign irq     = r_irq;

endmodule

// File: tb/tb_gpio_irq.sv
// Self-checking bench for gpio_irq: directed scenarios plus randomized pins/bus traffic
// against a history-window reference model. Works with or without GPIO_IRQ_DEBOUNCE_EN.
module tb_gpio_irq;
   import gpio_irq_pkg::*;

   localparam int NBTN = 2;
   localparam int NSW  = 2;
   localparam int NLED = 4;
   localparam int DEB  = 16;
   localparam int NIN  = NBTN + NSW;
`ifdef GPIO_IRQ_DEBOUNCE_EN
   localparam bit DEB_ON = 1'b1;
`else
   localparam bit DEB_ON = 1'b0;
`endif
   localparam int LAT = DEB_ON ? 2 + DEB : 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [NBTN-1:0] btn;
   logic [NSW-1:0]  sw;
   logic [NLED-1:0] led;
   logic            irq;

   gpio_irq_if bus ();

   gpio_irq #(.NBTN(NBTN), .NSW(NSW), .NLED(NLED), .DEB_CYCLES(DEB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .btn (btn),
      .sw  (sw),
      .led (led),
      .irq (irq)
   );

   // ---------------- clock/reset ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [NIN-1:0]  hist[$];
   logic [NLED-1:0] m_led;
   logic [NIN-1:0]  m_en, m_pend, m_sel, m_deb, m_deb_d;
   logic            m_irq;

   int n_checks = 0;
   int n_errors = 0;

   task automatic model_edge();
      logic [NIN-1:0]  pins, nd, set, w1c, v;
      logic [NLED-1:0] dl;
      logic            n_irq;
      bit              all_new;
      int              n;
      pins = {sw, btn};
      if (rst) begin
         m_led = '1; m_en = '0; m_pend = '0; m_sel = '0;
         m_deb = '0; m_deb_d = '0; m_irq = 1'b0;
         hist.delete();
         for (int k = 0; k < DEB + 4; k++) hist.push_back('0);
         return;
      end
      hist.push_back(pins);
      if (hist.size() > DEB + 8) void'(hist.pop_front());
      n  = hist.size();
      nd = m_deb;
      if (DEB_ON) begin
         // Stable value flips once the synchronised pin has shown the other level DEB times in a row.
         for (int i = 0; i < NIN; i++) begin
            all_new = 1'b1;
            for (int j = 2; j <= DEB + 1; j++) begin
               v = hist[n - 1 - j];
               if (v[i] == m_deb[i]) all_new = 1'b0;
            end
            if (all_new) nd[i] = ~m_deb[i];
         end
      end else begin
         nd = hist[n - 2];
      end
      set = (m_deb & ~m_deb_d & ~m_sel) | (~m_deb & m_deb_d & m_sel);
      n_irq = |(m_pend & m_en);
      w1c = (bus.we && bus.a == 4'd5) ? bus.d[NIN-1:0] : '0;
      m_pend = (m_pend & ~w1c) | set;
      if (bus.we) begin
         dl = bus.d[NLED-1:0];
         case (bus.a)
            4'd1: m_led = dl;
            4'd2: m_led = m_led | dl;
            4'd3: m_led = m_led & ~dl;
            4'd4: m_en  = bus.d[NIN-1:0];
            4'd6: m_sel = bus.d[NIN-1:0];
            default: ;
         endcase
      end
      m_deb_d = m_deb;
      m_deb   = nd;
      m_irq   = n_irq;
   endtask

   function automatic logic [31:0] exp_read(input logic [3:0] addr);
      case (addr)
         4'd0:    return 32'(m_deb);
         4'd1:    return 32'(m_led);
         4'd4:    return 32'(m_en);
         4'd5:    return 32'(m_pend);
         4'd6:    return 32'(m_sel);
         default: return 32'd0;
      endcase
   endfunction

   // ---------------- scoreboard check ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("led", 32'(led), 32'(m_led));
      check("irq", 32'(irq), 32'(m_irq));
      check("spo", bus.spo, exp_read(bus.a));
   endtask

   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
      bus.a = addr; bus.d = data; bus.we = 1'b1;
      tick();
      bus.we = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
      bus.a = addr;
      #1;
      check(tag, bus.spo, exp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int             hold[NIN];
      logic [NIN-1:0] pins;
      int             r;

      rst = 1'b1; btn = '0; sw = '0;
      bus.a = '0; bus.d = '0; bus.we = 1'b0;
      ticks(2);
      rst = 1'b0;

      check("rst_led", 32'(led), 32'hF);
      check("rst_irq", 32'(irq), 32'h0);
      read_check("rst_in", ADDR_IN, 32'h0);
      read_check("rst_en", ADDR_IRQ_EN, 32'h0);
      read_check("rst_pend", ADDR_IRQ_PEND, 32'h0);
      read_check("rst_sel", ADDR_EDGE_SEL, 32'h0);

      bus_write(ADDR_IRQ_EN, 32'h1);
      bus_write(ADDR_EDGE_SEL, 32'h0);

`ifdef GPIO_IRQ_DEBOUNCE_EN
      btn[0] = 1'b1;
      bus.a = ADDR_IN;
      ticks(10);
      btn[0] = 1'b0;
      ticks(30);
      read_check("glitch_in", ADDR_IN, 32'h0);
      read_check("glitch_pend", ADDR_IRQ_PEND, 32'h0);
`endif

      // Pin rise: IN changes exactly LAT edges later, pend one edge after, irq one more.
      btn[0] = 1'b1;
      bus.a = ADDR_IN;
      ticks(LAT - 1);
      read_check("lat_in_early", ADDR_IN, 32'h0);
      tick();
      read_check("lat_in", ADDR_IN, 32'h1);
      tick();
      read_check("rise_pend", ADDR_IRQ_PEND, 32'h1);
      check("rise_irq_early", 32'(irq), 32'h0);
      tick();
      check("rise_irq", 32'(irq), 32'h1);
      bus_write(ADDR_IRQ_PEND, 32'h1);
      read_check("w1c_pend", ADDR_IRQ_PEND, 32'h0);
      tick();
      check("w1c_irq", 32'(irq), 32'h0);

      // sw[0] (bit 2) on falling-edge select.
      bus_write(ADDR_EDGE_SEL, 32'h4);
      bus_write(ADDR_IRQ_EN, 32'h4);
      sw[0] = 1'b1;
      ticks(LAT + 3);
      read_check("fall_sel_rise", ADDR_IRQ_PEND, 32'h0);
      sw[0] = 1'b0;
      ticks(LAT);
      bus_write(ADDR_IRQ_PEND, 32'h4);
      read_check("w1c_vs_edge", ADDR_IRQ_PEND, 32'h4);
      tick();
      check("fall_irq", 32'(irq), 32'h1);

      // Reset while pending.
      bus_write(ADDR_LED, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_led", 32'(led), 32'hF);
      check("mid_rst_irq", 32'(irq), 32'h0);
      read_check("mid_rst_pend", ADDR_IRQ_PEND, 32'h0);
      read_check("mid_rst_in", ADDR_IN, 32'h0);

      // LED register family.
      bus_write(ADDR_LED, 32'h0);
      check("led_wr0", 32'(led), 32'h0);
      bus_write(ADDR_LED_SET, 32'h5);
      check("led_set", 32'(led), 32'h5);
      bus_write(ADDR_LED_CLR, 32'h1);
      check("led_clr", 32'(led), 32'h4);
      read_check("led_set_rd", ADDR_LED_SET, 32'h0);
      bus_write(ADDR_LED, 32'hFFFF_FFF0);
      check("led_wide", 32'(led), 32'h0);
      read_check("led_rd", ADDR_LED, 32'h0);
      bus_write(ADDR_IRQ_EN, 32'hFFFF_FFFF);
      read_check("en_wide", ADDR_IRQ_EN, 32'hF);
      bus_write(4'd9, 32'hFFFF_FFFF);
      read_check("unmapped", 4'd9, 32'h0);

      // Randomized pins with random hold times, random bus traffic, rare resets.
      pins = {sw, btn};
      for (int i = 0; i < NIN; i++) hold[i] = $urandom_range(1, 40);
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < NIN; i++) begin
            if (hold[i] == 0) begin
               pins[i] = ~pins[i];
               hold[i] = $urandom_range(1, 40);
            end else begin
               hold[i]--;
            end
         end
         {sw, btn} = pins;
         r = $urandom_range(0, 399);
         rst    = (r == 0);
         bus.we = ($urandom_range(0, 99) < 30);
         bus.a  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
         bus.d  = $urandom;
         tick();
      end
      rst = 1'b0;
      bus.we = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
